// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, data width, framing constants.
// Optional second stop bit is enabled with the UART_TX_TWO_STOP_EN macro.
package uart_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned CNT_WIDTH  = 3;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Gray-like encoding so adjacent states differ in one bit.
    typedef enum logic [2:0] {
        StIdle   = 3'b000,
        StStart  = 3'b001,
        StData   = 3'b011,
        StParity = 3'b010,
`ifdef UART_TX_TWO_STOP_EN
        StStop2  = 3'b111,
`endif
        StStop   = 3'b110
    } uart_state_e;

    // Parity bit for a byte: even (typ=0) or odd (typ=1).
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data, input logic typ);
        return (^data) ^ typ;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel request / serial output bundle for the UART transmitter.
interface uart_tx_if;
    import uart_pkg::*;

    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic                  tx_out;
    logic                  busy;

    modport master (
        output p_data, data_valid, par_en, par_typ,
        input  tx_out, busy
    );

    modport slave (
        input  p_data, data_valid, par_en, par_typ,
        output tx_out, busy
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// Byte shift register, bit counter and parity latch for the UART transmitter.
module uart_tx_serializer
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_typ,
    output logic                  o_lsb,
    output logic                  o_next,
    output logic                  o_parity,
    output logic                  o_done
);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_parity;

    // Latch the byte and its parity on load; advance one bit per shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_parity <= 1'b0;
        end else if (i_load) begin
            r_shift  <= i_data;
            r_cnt    <= '0;
            r_parity <= calc_parity(i_data, i_par_typ);
        end else if (i_shift) begin
            r_shift  <= {1'b0, r_shift[DATA_WIDTH-1:1]};
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // o_lsb is the bit currently due; o_next is the one after a shift.
    assign o_lsb    = r_shift[0];
    assign o_next   = r_shift[1];
    assign o_parity = r_parity;
    assign o_done   = (r_cnt == CNT_WIDTH'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one serial bit per clk, optional parity, one stop bit
// (two with UART_TX_TWO_STOP_EN defined). Outputs are registered.
module uart_tx
    import uart_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);

    uart_state_e r_state;
    logic        r_tx;
    logic        r_busy;
    logic        r_par_en;

    logic w_load;
    logic w_shift;
    logic w_lsb;
    logic w_next;
    logic w_parity;
    logic w_done;

    assign w_load  = (r_state == StIdle) && bus.data_valid;
    assign w_shift = (r_state == StData) && !w_done;

    uart_tx_serializer u_serializer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_shift   (w_shift),
        .i_data    (bus.p_data),
        .i_par_typ (bus.par_typ),
        .o_lsb     (w_lsb),
        .o_next    (w_next),
        .o_parity  (w_parity),
        .o_done    (w_done)
    );

    // Frame sequencer; tx/busy are loaded with the value of the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_tx     <= STOP_BIT;
            r_busy   <= 1'b0;
            r_par_en <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.data_valid) begin
                        r_state  <= StStart;
                        r_tx     <= START_BIT;
                        r_busy   <= 1'b1;
                        r_par_en <= bus.par_en;
                    end else begin
                        r_tx   <= STOP_BIT;
                        r_busy <= 1'b0;
                    end
                end
                StStart: begin
                    r_state <= StData;
                    r_tx    <= w_lsb;
                end
                StData: begin
                    if (!w_done) begin
                        r_tx <= w_next;
                    end else if (r_par_en) begin
                        r_state <= StParity;
                        r_tx    <= w_parity;
                    end else begin
                        r_state <= StStop;
                        r_tx    <= STOP_BIT;
                    end
                end
                StParity: begin
                    r_state <= StStop;
                    r_tx    <= STOP_BIT;
                end
`ifdef UART_TX_TWO_STOP_EN
                StStop: begin
                    r_state <= StStop2;
                    r_tx    <= STOP_BIT;
                end
                StStop2: begin
                    r_state <= StIdle;
                    r_tx    <= STOP_BIT;
                    r_busy  <= 1'b0;
                end
`else
                StStop: begin
                    r_state <= StIdle;
                    r_tx    <= STOP_BIT;
                    r_busy  <= 1'b0;
                end
`endif
                default: begin
                    r_state <= StIdle;
                    r_tx    <= STOP_BIT;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_out = r_tx;
    assign bus.busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of single frames plus hand-written
// sequences for held requests, mid-frame data change and mid-frame reset.
module tb_uart_tx;

`ifdef UART_TX_TWO_STOP_EN
    localparam int ExtraStop = 1;
`else
    localparam int ExtraStop = 0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_typ;
        logic       exp_par;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    uart_tx_if bus ();

    uart_tx u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] at %0t: got %b expected %b", name, idx, $time, act, exp);
        end
    endtask

    // Present a request at this negedge; returns at the negedge showing the start bit.
    task automatic start_req(input logic [7:0] d, input logic pe, input logic pt);
        bus.p_data     = d;
        bus.par_en     = pe;
        bus.par_typ    = pt;
        bus.data_valid = 1'b1;
        @(negedge clk);
    endtask

    // Check every cycle of a frame; returns at the negedge of the following cycle.
    task automatic check_frame(input logic [7:0] d, input logic pe, input logic ep,
                               input logic hold, input logic mid_en, input logic [7:0] mid_d);
        int   len;
        logic exp;
        len = 10 + (pe ? 1 : 0) + ExtraStop;
        for (int i = 0; i < len; i++) begin
            if (i == 0 && !hold) bus.data_valid = 1'b0;
            if (i == 2 && mid_en) bus.p_data = mid_d;
            if (i == 0)                exp = 1'b0;
            else if (i <= 8)           exp = d[i-1];
            else if (pe && i == 9)     exp = ep;
            else                       exp = 1'b1;
            check("tx_out", i, bus.tx_out, exp);
            check("busy", i, bus.busy, 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input int idx);
        check("idle_tx", idx, bus.tx_out, 1'b1);
        check("idle_busy", idx, bus.busy, 1'b0);
    endtask

    vec_t vecs [7];

    initial begin
        n_vec = 0;
        n_err = 0;
        vecs[0] = '{data: 8'hA5, par_en: 1'b0, par_typ: 1'b0, exp_par: 1'b0};
        vecs[1] = '{data: 8'hA5, par_en: 1'b1, par_typ: 1'b0, exp_par: 1'b0};
        vecs[2] = '{data: 8'hA5, par_en: 1'b1, par_typ: 1'b1, exp_par: 1'b1};
        vecs[3] = '{data: 8'h07, par_en: 1'b1, par_typ: 1'b0, exp_par: 1'b1};
        vecs[4] = '{data: 8'h00, par_en: 1'b1, par_typ: 1'b1, exp_par: 1'b1};
        vecs[5] = '{data: 8'hFF, par_en: 1'b1, par_typ: 1'b0, exp_par: 1'b0};
        vecs[6] = '{data: 8'h5A, par_en: 1'b1, par_typ: 1'b1, exp_par: 1'b1};

        rst            = 1'b0;
        bus.p_data     = 8'h00;
        bus.data_valid = 1'b0;
        bus.par_en     = 1'b0;
        bus.par_typ    = 1'b0;
        #12;
        check_idle(0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle(1);

        for (int v = 0; v < 7; v++) begin
            start_req(vecs[v].data, vecs[v].par_en, vecs[v].par_typ);
            check_frame(vecs[v].data, vecs[v].par_en, vecs[v].exp_par, 1'b0, 1'b0, 8'h00);
            check_idle(10 + v);
        end

        // Held request: second frame starts after exactly one idle cycle.
        start_req(8'h3C, 1'b0, 1'b0);
        check_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3);
        check_idle(20);
        @(negedge clk);
        check_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_idle(21);

        // Input change mid-frame must not disturb the latched byte.
        start_req(8'h00, 1'b1, 1'b0);
        check_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF);
        check_idle(22);

        // Reset during data bit 4, then a request right at release.
        start_req(8'h00, 1'b0, 1'b0);
        bus.data_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("pre_rst_tx", i, bus.tx_out, 1'b0);
            check("pre_rst_busy", i, bus.busy, 1'b1);
            if (i < 5) @(negedge clk);
        end
        #2 rst = 1'b0;
        #1 check_idle(30);
        @(negedge clk);
        check_idle(31);
        rst = 1'b1;
        start_req(8'h55, 1'b0, 1'b0);
        check_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_idle(32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have port clk  input  1  transmit bit clock; one serial bit per clk cycle; all logic on the rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port p_data  input  8  parallel byte to transmit.
REQ-004 SHALL have port data_valid  input  1  request to transmit p_data; single-cycle or held.
REQ-005 SHALL have port par_en  input  1  1 = append parity bit.
REQ-006 SHALL have port par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-007 SHALL have port tx_out  output  1  serial line; idle high; registered.
REQ-008 SHALL have port busy  output  1  high while a frame is in flight; registered.

Function
REQ-009 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP, plus STOP2 under REQ-024.
REQ-010 SHALL accept a request only in IDLE with data_valid=1; p_data, par_en and par_typ are latched at that edge.
REQ-011 SHALL ignore data_valid in every non-IDLE state; the latched byte is unaffected by input changes mid-frame.
REQ-012 SHALL drive the start bit (0) on tx_out in the cycle after acceptance, with busy=1 in the same cycle (latency 1).
REQ-013 SHALL send the 8 data bits LSB first, one per cycle, in DATA using a 3-bit bit counter that runs 0..7.
REQ-014 SHALL move DATA->PARITY after bit 7 if latched par_en=1, otherwise DATA->STOP.
REQ-015 SHALL set the parity bit to XOR of the latched byte when par_typ=0, and to its inverse when par_typ=1.
REQ-016 SHALL drive the stop bit as 1 for one cycle.
REQ-017 SHALL return to IDLE after STOP, with tx_out=1 and busy=0.
REQ-018 SHALL guarantee at least one idle-high cycle between frames; back-to-back data_valid is accepted at the earliest in the first IDLE cycle.
REQ-019 SHALL produce a frame length of 10 cycles without parity and 11 cycles with parity, counted from start bit to stop bit inclusive.
REQ-020 SHALL keep busy high for exactly the frame length, from the start-bit cycle through the last stop-bit cycle.
REQ-021 SHALL treat an illegal state encoding as IDLE, with tx_out=1 and busy=0 on the next cycle.

Reset
REQ-022 SHALL, on asserted rst at any time including mid-frame, immediately set state=IDLE, tx_out=1, busy=0, bit counter=0 and the latched byte=0.
REQ-023 SHALL accept a request on the first rising edge after rst deassertion if data_valid=1.

Configuration
REQ-024 SHALL, with UART_TX_TWO_STOP_EN defined, add a STOP2 state after STOP, giving two stop-bit cycles at 1 and frame lengths of 11 (no parity) or 12 (parity); busy stays high through STOP2.
REQ-025 SHALL, without UART_TX_TWO_STOP_EN, exclude the STOP2 state and logic entirely, with one stop bit per REQ-016.

Structure
REQ-026 SHALL take the state encodings (3-bit: IDLE=000, START=001, DATA=011, PARITY=010, STOP=110, STOP2=111), DATA_WIDTH=8 and the START_BIT/STOP_BIT constants from the shared package uart_pkg.
REQ-027 SHALL place the shift register, bit counter and parity computation in one sub-module, uart_tx_serializer, controlled by the FSM through load/shift enables and a done flag.

Verification
REQ-028 SHALL cover: reset, then p_data=0xA5 with par_en=0 and a 1-cycle pulse -> tx_out = 0,1,0,1,0,0,1,0,1,1 then idle, busy high for 10 cycles.
REQ-029 SHALL cover: p_data=0xA5 with par_en=1, par_typ=0 -> parity bit 0; same with par_typ=1 -> parity bit 1; busy high for 11 cycles.
REQ-030 SHALL cover: p_data=0x07 with par_en=1, par_typ=0 -> parity bit 1.
REQ-031 SHALL cover: data_valid held high continuously with 0x3C then 0xC3 -> two full frames separated by exactly one idle-high cycle, and no request accepted while busy.
REQ-032 SHALL cover: p_data changed to 0xFF during the DATA state of a 0x00 frame -> all 8 data bits transmitted as 0.
REQ-033 SHALL cover: rst asserted during bit 4 of a frame -> tx_out=1 and busy=0 at once; a new 0x55 request after release produces a clean full frame.
